// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit multiplexed seven-segment display.
// Latency: none (constants only).
// Backpressure: not applicable.
//
// Contents: digit count, active-low "all off" levels for anodes, segments
// and decimal point, and the 16-entry hex-to-segment table (bit 0 = a ..
// bit 6 = g, active-low).
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;
  localparam logic       DP_OFF      = 1'b1;

  // Indexed by nibble value; first element listed is entry 15 (F).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_nibble - 4-bit value to show; o_seg - segments a..g (bit 0 = a), active-low.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode hex display with dead time and leading-zero blanking.
// Latency: AN/SEG/DP are registered one cycle after the scan counters; FRAME is combinational with the snapshot load.
// Backpressure: none; EN low freezes the scan and blanks the anodes.
//
// Ports:
//   CLK, RST           - clock, synchronous active-high reset
//   DISREG[31:0]       - display value, nibble i -> digit i (digit 0 rightmost);
//                        expected to be wired straight from the CPU display register
//   DP_EN[7:0]         - decimal point request per digit
//   EN, LZB            - display enable, leading-zero blanking enable
//   AN[7:0], SEG[6:0]  - active-low anodes and cathodes (SEG bit 0 = a)
//   DP                 - active-low decimal point cathode
//   FRAME              - one-cycle pulse in the cycle the snapshot is taken
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DISREG,
  input  logic [7:0]  DP_EN,
  input  logic        EN,
  input  logic        LZB,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int DIG_W  = $clog2(NUM_DIGITS);

  logic [SLOT_W-1:0] r_slot;
  logic [DIG_W-1:0]  r_digit;
  logic [31:0]       r_shadow;
  logic [7:0]        r_shadow_dp;
  logic              r_load_pend;   // snapshot owed since reset release
  logic [7:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic              w_slot_last;
  logic              w_frame_wrap;
  logic              w_load;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg;
  logic [DIG_W-1:0]  w_top_digit;
  logic              w_lz_blank;
  logic              w_in_blank;
  logic              w_an_on;
  logic [7:0]        w_an_next;

  assign w_slot_last  = (r_slot == SLOT_W'(DIGIT_CYCLES - 1));
  assign w_frame_wrap = w_slot_last && (r_digit == DIG_W'(NUM_DIGITS - 1));

  // The snapshot is taken on the same edge that wraps the scan to digit 0,
  // so digit 0 of the new frame is the first to see the new value.
  assign w_load = !RST && EN && (r_load_pend || w_frame_wrap);

  assign w_nibble = r_shadow[{r_digit, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Index of the most significant nonzero shadow nibble; 0 when the value is
  // all zeros, which keeps digit 0 lit in that case.
  always_comb begin
    w_top_digit = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_shadow[4*i +: 4] != 4'h0) begin
        w_top_digit = DIG_W'(i);
      end
    end
  end

  // A requested decimal point keeps its digit visible even when it is a leading zero.
  assign w_lz_blank = LZB && (r_digit > w_top_digit) && !r_shadow_dp[r_digit];
  assign w_in_blank = (r_slot < SLOT_W'(BLANK_CYCLES));
  assign w_an_on    = EN && !w_in_blank && !w_lz_blank;
  assign w_an_next  = w_an_on ? ~(8'b1 << r_digit) : AN_ALL_OFF;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slot      <= '0;
      r_digit     <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_load_pend <= 1'b1;
      r_an        <= AN_ALL_OFF;
      r_seg       <= SEG_ALL_OFF;
      r_dp        <= DP_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg;
      r_dp  <= ~r_shadow_dp[r_digit];

      if (EN) begin
        if (w_slot_last) begin
          r_slot  <= '0;
          r_digit <= r_digit + DIG_W'(1);
        end else begin
          r_slot  <= r_slot + SLOT_W'(1);
        end
      end

      if (w_load) begin
        r_shadow    <= DISREG;
        r_shadow_dp <= DP_EN;
        r_load_pend <= 1'b0;
      end
    end
  end

  assign AN    = r_an;
  assign SEG   = r_seg;
  assign DP    = r_dp;
  assign FRAME = w_load;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DC = 4;
  localparam int BC = 1;
  localparam int ND = 8;
  localparam int FRAME_LEN = ND * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        lzb = 1'b0;
  logic [31:0] disreg = '0;
  logic [7:0]  dp_en = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .DISREG (disreg),
    .DP_EN  (dp_en),
    .EN     (en),
    .LZB    (lzb),
    .AN     (an),
    .SEG    (seg),
    .DP     (dp),
    .FRAME  (frame)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference segment codes (active-low, bit 0 = a).
  logic [6:0] ref_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position within the frame as one number; digit and
  // slot are derived by division. State here is what the DUT holds after
  // the next clock edge.
  int          m_pos = 0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_sdp = '0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_an = '0;
  logic [6:0]  m_seg = '0;
  bit          m_dp = 1'b0;
  bit          m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Monitor: one DUT observation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      chk("AN", 32'(an), 32'(e.an));
      chk("SEG", 32'(seg), 32'(e.seg));
      chk("DP", 32'(dp), 32'(e.dp));
      chk("FRAME", 32'(frame), 32'(e.frame));
    end
  end

  task automatic model_next(input bit r, input bit e, input bit l, input logic [31:0] d,
                            input logic [7:0] p, input bit fr);
    int digit, slot, hi, nib;
    bit show;
    if (r) begin
      m_pos = 0; m_shadow = '0; m_sdp = '0; m_pend = 1'b1;
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
      m_valid = 1'b1;
    end else begin
      digit = m_pos / DC;
      slot  = m_pos % DC;
      hi = 0;
      for (int i = 0; i < ND; i++)
        if (((m_shadow >> (4 * i)) & 32'hF) != 0) hi = i;
      show = e && (slot >= BC) && !(l && (digit > hi) && !m_sdp[digit]);
      m_an  = show ? (8'hFF & ~(8'd1 << digit)) : 8'hFF;
      nib   = int'((m_shadow >> (4 * digit)) & 32'hF);
      m_seg = ref_tab[nib];
      m_dp  = !m_sdp[digit];
      if (e) begin
        if (fr) begin
          m_shadow = d; m_sdp = p; m_pend = 1'b0;
        end
        m_pos = (m_pos + 1) % FRAME_LEN;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic cycle(input bit r, input bit e, input bit l, input logic [31:0] d,
                       input logic [7:0] p);
    bit fr;
    @(posedge clk);
    #1;
    rst = r; en = e; lzb = l; disreg = d; dp_en = p;
    fr = !r && e && (m_pend || (m_pos == FRAME_LEN - 1));
    if (m_valid) exp_q.push_back('{an: m_an, seg: m_seg, dp: m_dp, frame: fr});
    model_next(r, e, l, d, p, fr);
  endtask

  task automatic run(input int n, input bit e, input bit l, input logic [31:0] d,
                     input logic [7:0] p);
    for (int i = 0; i < n; i++) cycle(1'b0, e, l, d, p);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h0);
  endtask

  // Advance until the model says the scan sits at the given digit/slot.
  task automatic run_to(input int pos, input bit l, input logic [31:0] d, input logic [7:0] p);
    int guard = 0;
    while (m_pos != pos && guard < 4 * FRAME_LEN) begin
      cycle(1'b0, 1'b1, l, d, p);
      guard++;
    end
    n_checks++;
    if (m_pos != pos) begin
      n_fail++;
      $display("FAIL run_to: position %0d not reached, at %0d", pos, m_pos);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  rp;
    bit          rl;

    do_reset(3);

    // Basic scan with a distinct value per digit.
    run(3 * FRAME_LEN, 1'b1, 1'b0, 32'h1234_5678, 8'h00);

    // No tearing: value changes while digit 3 is being shown.
    do_reset(2);
    run(FRAME_LEN, 1'b1, 1'b0, 32'h0, 8'h00);
    run_to(3 * DC + 1, 1'b0, 32'h0, 8'h00);
    run(2 * FRAME_LEN, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00);

    // Leading-zero blanking cases.
    do_reset(2);
    run(2 * FRAME_LEN, 1'b1, 1'b1, 32'h0000_00A0, 8'h00);
    run(2 * FRAME_LEN, 1'b1, 1'b1, 32'h0000_0000, 8'h00);
    run(2 * FRAME_LEN, 1'b1, 1'b1, 32'h0000_0000, 8'h10);
    run(2 * FRAME_LEN, 1'b1, 1'b1, 32'h0030_0000, 8'h81);

    // Enable dropped for 10 cycles in the middle of a slot, then across a frame wrap.
    run_to(2 * DC + 2, 1'b0, 32'hCAFE_BABE, 8'h5A);
    run(10, 1'b0, 1'b0, 32'h0123_4567, 8'hFF);
    run(FRAME_LEN + 8, 1'b1, 1'b0, 32'h0123_4567, 8'hFF);
    run_to(FRAME_LEN - 1, 1'b0, 32'h89AB_CDEF, 8'h00);
    run(5, 1'b0, 1'b0, 32'h89AB_CDEF, 8'h00);
    run(FRAME_LEN, 1'b1, 1'b0, 32'h89AB_CDEF, 8'h00);

    // Reset mid-frame at digit 5, with EN low during the reset cycle.
    run_to(5 * DC + 2, 1'b0, 32'h7654_3210, 8'h0F);
    cycle(1'b1, 1'b0, 1'b0, 32'h7654_3210, 8'h0F);
    run(2 * FRAME_LEN, 1'b1, 1'b0, 32'h7654_3210, 8'h0F);

    // Randomized traffic.
    rd = 32'h0; rp = 8'h0; rl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rd = $urandom() >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 31) == 0) rp = (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom()));
      if ($urandom_range(0, 63) == 0) rl = ~rl;
      if ($urandom_range(0, 499) == 0)
        cycle(1'b1, 1'($urandom_range(0, 1)), rl, rd, rp);
      else
        cycle(1'b0, ($urandom_range(0, 9) != 0), rl, rd, rp);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d observations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
